// File: rtl/stream_ring_buffer.sv
// stream_ring_buffer: circular buffer, K-wide parallel write, J-wide read.
// Own wrapping pointers and occupancy count; valid/ready on both sides.
module stream_ring_buffer #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 4,
  parameter int K     = 8,
  parameter int J     = 4,
  parameter int BIT   = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH*K-1:0] par_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH*J-1:0] par_out,
  output logic [BIT:0]       count,
  output logic               full,
  output logic               empty
);

  localparam logic [BIT:0] KC  = (BIT+1)'(K);
  localparam logic [BIT:0] JC  = (BIT+1)'(J);
  localparam logic [BIT:0] SC  = (BIT+1)'(SIZE);
  localparam logic [BIT:0] LIM = (BIT+1)'(SIZE - K);

  logic [WIDTH-1:0] r_mem [SIZE];
  logic [BIT-1:0]   r_wr_ptr;
  logic [BIT-1:0]   r_rd_ptr;
  logic [BIT:0]     r_count;
  logic             w_wr;
  logic             w_rd;

  assign in_ready  = (r_count <= LIM);
  assign out_valid = (r_count >= JC);
  assign full      = (r_count == SC);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_wr      = in_valid && in_ready;
  assign w_rd      = out_valid && out_ready;

  // Head-of-queue view: J entries from rd_ptr, wrapping mod SIZE
  always_comb begin
    par_out = '0;
    for (int i = 0; i < J; i++) begin
      par_out[i*WIDTH +: WIDTH] = r_mem[r_rd_ptr + BIT'(i)];
    end
  end

  // Pointer/count state; flush keeps memory, reset zeroes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + BIT'(K);
      if (w_rd) r_rd_ptr <= r_rd_ptr + BIT'(J);
      r_count <= r_count + (w_wr ? KC : '0) - (w_rd ? JC : '0);
    end
  end

  // Storage: K elements land at wr_ptr.., straddling the top if needed
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SIZE; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!clr && w_wr) begin
      for (int i = 0; i < K; i++) begin
        r_mem[r_wr_ptr + BIT'(i)] <= par_in[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule
